input_debounce: RTL and testbench

INPUT_DEBOUNCE -- requirements
Module: input_debounce

---
 rtl/input_debounce.sv | 58 +++++
 tb/tb_input_debounce.sv | 96 +++++++++
 2 files changed

// File: rtl/input_debounce.sv
// input_debounce: 2-flop synchronizer plus counter-qualified debounce FSM (STABLE/CHECK).
// Define DEBOUNCE_EDGE_PULSE_EN to build the registered rise/fall pulse outputs; otherwise they are tied to 0.
module input_debounce #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic busy
);
   typedef enum logic {STABLE, CHECK} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);
   state_t state, state_n;
   logic s1, s2, dout_n, diff, done;
   logic [CNT_W-1:0] cnt, cnt_n;
   assign diff = s2 ^ dout;
   assign done = diff && state == CHECK && cnt == LAST;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= STABLE;
         cnt   <= '0;
         dout  <= 1'b0;
      end else begin
         s1    <= din;
         s2    <= s1;
         state <= state_n;
         cnt   <= cnt_n;
         dout  <= dout_n;
      end
   end
   // A glitch back to dout or a completed qualification both return to STABLE with cnt cleared.
   always_comb begin
      state_n = (!diff || done) ? STABLE : CHECK;
      cnt_n   = (state_n == STABLE) ? '0 : (state == STABLE) ? CNT_W'(1) : cnt + 1'b1;
      dout_n  = done ? s2 : dout;
   end
   assign busy = (state == CHECK);
`ifdef DEBOUNCE_EDGE_PULSE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= done & s2;
         fall <= done & ~s2;
      end
   end
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: randomized + directed stimulus, reference model feeds a scoreboard queue checked by a monitor.
module tb_input_debounce;
   localparam int SC = 4;
   logic clk = 1'b0, rst = 1'b1, din = 1'b1;
   logic dout, rise, fall, busy;
   int checks = 0, errors = 0;
   typedef struct {logic dout; logic rise; logic fall; logic busy;} exp_t;
   exp_t sb[$];
   // Reference: a level that lags din by two edges, and a run length of consecutive disagreeing edges.
   logic p1 = 1'b0, p2 = 1'b0, m_dout = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
   int run = 0;

   input_debounce #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .din(din), .dout(dout), .rise(rise), .fall(fall), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      exp_t e;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (rst) begin
         p1 = 1'b0; p2 = 1'b0; m_dout = 1'b0; run = 0;
      end else begin
         if (p2 != m_dout) begin
            run++;
            if (run == SC) begin
`ifdef DEBOUNCE_EDGE_PULSE_EN
               m_rise = p2;
               m_fall = !p2;
`endif
               m_dout = p2;
               run = 0;
            end
         end else run = 0;
         p2 = p1;
         p1 = din;
      end
      e.dout = m_dout; e.rise = m_rise; e.fall = m_fall; e.busy = (run > 0);
      sb.push_back(e);
   end

   task automatic chk(input string name, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, want, $time);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("dout", dout, e.dout);
         chk("rise", rise, e.rise);
         chk("fall", fall, e.fall);
         chk("busy", busy, e.busy);
         chk("rise_and_fall", rise & fall, 1'b0);
      end
   end

   task automatic drive(input logic r, input logic d, input int n);
      rst = r;
      din = d;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      drive(1, 1, 3);
      drive(0, 0, 6);
      drive(0, 1, 12);
      drive(0, 0, 12);
      drive(0, 1, 3);
      drive(0, 0, 12);
      drive(0, 1, 3);
      drive(1, 1, 1);
      drive(0, 1, 12);
      for (int i = 0; i < 40; i++) drive(0, i[0], 1);
      drive(0, 0, 12);
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 14) == 0) drive(1, 1'($urandom_range(0, 1)), $urandom_range(1, 2));
         else drive(0, 1'($urandom_range(0, 1)), $urandom_range(1, 2 * SC + 3));
      end
      drive(0, din, 2);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
